x2050_brk_arb: RTL and testbench

//  Break-in request arbiter/scheduler in front of the x2050 break-in (br) logic. Collects

---
 rtl/x2050_brk_arb.sv | 119 +++++++++++
 tb/tb_x2050_brk_arb.sv | 136 +++++++++++++
 2 files changed

// File: rtl/x2050_brk_arb.sv
// x2050_brk_arb: break-in request arbiter that selects a channel routine for br and tracks its owner
// Ports: i_clk, i_reset_n (sync, active-low); i_req[NCH] request levels; i_ch_addr[NCH*AW]
// per-channel start addresses; i_firstcycle / i_break_out from br; o_routine_request and
// o_routine_addr to br; o_grant (one-hot owner); o_ack (one-cycle accept pulse); o_busy; o_error (sticky).
// Optional X2050_BRK_RR_EN: round-robin arbitration instead of fixed priority (index 0 highest).
module x2050_brk_arb #(
  parameter int NCH = 4,
  parameter int AW  = 13
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [NCH-1:0]    i_req,
  input  logic [NCH*AW-1:0] i_ch_addr,
  input  logic              i_firstcycle,
  input  logic              i_break_out,
  output logic              o_routine_request,
  output logic [AW-1:0]     o_routine_addr,
  output logic [NCH-1:0]    o_grant,
  output logic [NCH-1:0]    o_ack,
  output logic              o_busy,
  output logic              o_error
);
  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [NCH-1:0] ONE = NCH'(1);
  typedef enum logic [1:0] {IDLE, REQ, RUN} state_t;
  state_t state, state_n;
  logic armed, armed_n, err, err_n;
  logic [SW-1:0] sel, sel_n, win;
  logic [AW-1:0] addr, addr_n;
  logic [NCH-1:0] grant, grant_n, ack, ack_n, mask;
`ifdef X2050_BRK_RR_EN
  logic [SW-1:0] ptr;
`endif
  // the running owner never competes for its own chain
  assign mask = (state == RUN) ? (i_req & ~grant) : i_req;
  always_comb begin
    win = '0;
`ifdef X2050_BRK_RR_EN
    for (int i = NCH; i >= 1; i--)
      if (mask[(int'(ptr) + i) % NCH]) win = SW'((int'(ptr) + i) % NCH);
`else
    for (int i = NCH - 1; i >= 0; i--)
      if (mask[i]) win = SW'(i);
`endif
  end
  always_comb begin
    state_n = state;
    armed_n = armed;
    sel_n   = sel;
    addr_n  = addr;
    grant_n = grant;
    ack_n   = '0;
    err_n   = err;
    if (state == IDLE) begin
      err_n = err | i_firstcycle | i_break_out;
      if (|i_req) begin
        sel_n   = win;
        addr_n  = i_ch_addr[int'(win)*AW +: AW];
        state_n = REQ;
      end
    end else if (state == REQ) begin
      err_n = err | i_break_out;
      if (i_firstcycle) begin
        ack_n   = ONE << sel;
        grant_n = ONE << sel;
        state_n = RUN;
      end
    end else if (i_firstcycle && armed) begin
      // chain: ownership moves directly, a simultaneous break_out is a protocol error
      err_n   = err | i_break_out;
      ack_n   = ONE << sel;
      grant_n = ONE << sel;
      armed_n = 1'b0;
    end else if (i_break_out) begin
      err_n   = err | i_firstcycle;
      grant_n = '0;
      armed_n = 1'b0;
      state_n = armed ? REQ : IDLE;
    end else begin
      err_n = err | i_firstcycle;
      if (|mask && !armed) begin
        sel_n   = win;
        addr_n  = i_ch_addr[int'(win)*AW +: AW];
        armed_n = 1'b1;
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state <= IDLE;
      armed <= 1'b0;
      sel   <= '0;
      addr  <= '0;
      grant <= '0;
      ack   <= '0;
      err   <= 1'b0;
`ifdef X2050_BRK_RR_EN
      ptr   <= SW'(NCH - 1);
`endif
    end else begin
      state <= state_n;
      armed <= armed_n;
      sel   <= sel_n;
      addr  <= addr_n;
      grant <= grant_n;
      ack   <= ack_n;
      err   <= err_n;
`ifdef X2050_BRK_RR_EN
      if (|ack_n) ptr <= sel;
`endif
    end
  end
  assign o_routine_request = (state == REQ) || (state == RUN && armed);
  assign o_routine_addr    = addr;
  assign o_grant           = grant;
  assign o_ack             = ack;
  assign o_busy            = state != IDLE;
  assign o_error           = err;
endmodule

// File: tb/tb_x2050_brk_arb.sv
// tb_x2050_brk_arb: randomized scoreboard bench for x2050_brk_arb against an owner/selection model
// The model tracks "routine owner" and "selected-but-not-accepted channel"; accepts push expected acks
// into a queue that the negedge monitor pops. Honours X2050_BRK_RR_EN like the design.
module tb_x2050_brk_arb;
  localparam int NCH = 4;
  localparam int AW  = 13;
  logic clk = 1'b0;
  logic i_reset_n, i_firstcycle, i_break_out;
  logic [NCH-1:0] i_req;
  logic [NCH*AW-1:0] i_ch_addr;
  logic o_routine_request, o_busy, o_error;
  logic [AW-1:0] o_routine_addr;
  logic [NCH-1:0] o_grant, o_ack;
  typedef struct {int ch; logic [AW-1:0] addr;} exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0;
  bit mon_on = 1'b0;
  int owner = -1, msel = -1;
  logic [AW-1:0] maddr = '0;
  bit merr = 1'b0;
`ifdef X2050_BRK_RR_EN
  int last = NCH - 1;
`endif
  x2050_brk_arb #(.NCH(NCH), .AW(AW)) dut (
    .i_clk(clk), .i_reset_n(i_reset_n), .i_req(i_req), .i_ch_addr(i_ch_addr),
    .i_firstcycle(i_firstcycle), .i_break_out(i_break_out),
    .o_routine_request(o_routine_request), .o_routine_addr(o_routine_addr),
    .o_grant(o_grant), .o_ack(o_ack), .o_busy(o_busy), .o_error(o_error)
  );
  always #5 clk = ~clk;
  function automatic int pick(input logic [NCH-1:0] m);
`ifdef X2050_BRK_RR_EN
    for (int k = 1; k <= NCH; k++) if (m[(last + k) % NCH]) return (last + k) % NCH;
`else
    for (int c = 0; c < NCH; c++) if (m[c]) return c;
`endif
    return -1;
  endfunction
  function automatic void select(input logic [NCH-1:0] m);
    msel  = pick(m);
    maddr = i_ch_addr[msel*AW +: AW];
  endfunction
  function automatic void accept();
    q.push_back('{msel, maddr});
`ifdef X2050_BRK_RR_EN
    last = msel;
`endif
    owner = msel;
    msel  = -1;
  endfunction
  always @(posedge clk) begin : model
    logic [NCH-1:0] m;
    if (!i_reset_n) begin
      owner = -1;
      msel  = -1;
      merr  = 1'b0;
      maddr = '0;
`ifdef X2050_BRK_RR_EN
      last  = NCH - 1;
`endif
    end else if (owner < 0 && msel < 0) begin
      merr |= i_firstcycle | i_break_out;
      if (i_req != 0) select(i_req);
    end else if (owner < 0) begin
      merr |= i_break_out;
      if (i_firstcycle) accept();
    end else if (i_firstcycle && msel >= 0) begin
      merr |= i_break_out;
      accept();
    end else if (i_break_out) begin
      merr |= i_firstcycle;
      owner = -1;
    end else begin
      merr |= i_firstcycle;
      m = i_req & ~(NCH'(1) << owner);
      if (msel < 0 && m != 0) select(m);
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  always @(negedge clk) if (mon_on) begin
    chk("grant", 32'(o_grant), owner >= 0 ? 32'(1) << owner : 32'(0));
    chk("busy", 32'(o_busy), 32'(owner >= 0 || msel >= 0));
    chk("request", 32'(o_routine_request), 32'(msel >= 0));
    chk("error", 32'(o_error), 32'(merr));
    if (msel >= 0) chk("addr", 32'(o_routine_addr), 32'(maddr));
    if (o_ack != 0 || q.size() != 0) begin
      if (q.size() == 0) chk("ack_unexpected", 32'(o_ack), 32'(0));
      else begin
        e = q.pop_front();
        chk("ack", 32'(o_ack), 32'(1) << e.ch);
        chk("ack_addr", 32'(o_routine_addr), 32'(e.addr));
      end
    end
  end
  initial begin
    i_reset_n = 1'b0;
    i_req = '0;
    i_ch_addr = '0;
    i_firstcycle = 1'b0;
    i_break_out = 1'b0;
    @(posedge clk);
    #1 mon_on = 1'b1;
    @(posedge clk);
    #1 i_reset_n = 1'b1;
    for (int n = 0; n < 6000; n++) begin
      i_reset_n = !(n >= 3000 && $urandom_range(0, 119) == 0);
      for (int k = 0; k < NCH; k++)
        if (i_req[k]) begin
          if (o_ack[k]) i_req[k] = 1'b0;
        end else if ($urandom_range(0, 5) == 0) begin
          i_req[k] = 1'b1;
          i_ch_addr[k*AW +: AW] = AW'($urandom);
        end
      i_firstcycle = (o_routine_request && $urandom_range(0, 2) == 0) ||
                     (n >= 3000 && $urandom_range(0, 19) == 0);
      i_break_out  = (o_grant != 0 && !i_firstcycle && $urandom_range(0, 3) == 0) ||
                     (n >= 3000 && $urandom_range(0, 19) == 0);
      @(posedge clk);
      #1;
    end
    i_req = '0;
    i_firstcycle = 1'b0;
    i_break_out = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("queue_empty", 32'(q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
